// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB-to-register-file bus bundle.
//   master: drives the MEM/WB fields and read indices, receives read data, forwarding and debug outputs
//   slave:  the write-back/register-file side
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [1:0]        mem_to_reg_in;
    logic              reg_write_in;
    logic [DATA_W-1:0] data_from_memory_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [ADDR_W-1:0] write_reg_in;
    logic [DATA_W-1:0] adder1_in;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] wb_data;
    logic              wb_commit;
    logic [CNT_W-1:0]  write_count;
    logic              illegal_sel;

    modport master (
        output mem_to_reg_in, reg_write_in, data_from_memory_in, alu_result_in,
               write_reg_in, adder1_in, read_reg1, read_reg2,
        input  read_data1, read_data2, wb_data, wb_commit, write_count, illegal_sel
    );

    modport slave (
        input  mem_to_reg_in, reg_write_in, data_from_memory_in, alu_result_in,
               write_reg_in, adder1_in, read_reg1, read_reg2,
        output read_data1, read_data2, wb_data, wb_commit, write_count, illegal_sel
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back stage and 32x32 register file with write-through read bypass.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : MEM/WB inputs, two ID read ports, wb_data forwarding value,
//                  wb_commit, saturating write_count, sticky illegal_sel
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic        clock,
    input  logic        reset,
    wb_regfile_if.slave bus
);
    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic [CNT_W-1:0]  cnt;
    logic              ill;

    assign bus.wb_data = bus.mem_to_reg_in == 2'b00 ? bus.alu_result_in :
                         bus.mem_to_reg_in == 2'b01 ? bus.data_from_memory_in :
                         bus.mem_to_reg_in == 2'b10 ? bus.adder1_in : '0;

    assign bus.wb_commit = bus.reg_write_in & (|bus.write_reg_in) &
                           (bus.mem_to_reg_in != 2'b11) & ~reset;

    // wb_commit already excludes register 0, so a matching index implies a live bypass
    assign bus.read_data1 = bus.read_reg1 == '0 ? '0 :
                            (bus.wb_commit && bus.write_reg_in == bus.read_reg1) ? bus.wb_data :
                            regs[bus.read_reg1];
    assign bus.read_data2 = bus.read_reg2 == '0 ? '0 :
                            (bus.wb_commit && bus.write_reg_in == bus.read_reg2) ? bus.wb_data :
                            regs[bus.read_reg2];

    assign bus.write_count = cnt;
    assign bus.illegal_sel = ill;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
            cnt <= '0;
            ill <= 1'b0;
        end else begin
            if (bus.wb_commit) regs[bus.write_reg_in] <= bus.wb_data;
            if (bus.wb_commit && !(&cnt)) cnt <= cnt + 1'b1;
            if (bus.reg_write_in && bus.mem_to_reg_in == 2'b11) ill <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile (full-width instance plus a CNT_W=4 instance).
module tb_wb_regfile;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic reset2 = 1'b1;
    int   passed = 0;
    int   total = 0;

    always #5 clock = ~clock;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) u_if ();
    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  u_if2 ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .bus(u_if.slave)
    );
    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut2 (
        .clock(clock), .reset(reset2), .bus(u_if2.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        u_if.mem_to_reg_in = 2'b00;
        u_if.reg_write_in = 1'b1;
        u_if.data_from_memory_in = '0;
        u_if.alu_result_in = 32'h0000_1234;
        u_if.write_reg_in = 5'd5;
        u_if.adder1_in = '0;
        u_if.read_reg1 = 5'd5;
        u_if.read_reg2 = 5'd0;
        u_if2.mem_to_reg_in = 2'b00;
        u_if2.reg_write_in = 1'b0;
        u_if2.data_from_memory_in = '0;
        u_if2.alu_result_in = '0;
        u_if2.write_reg_in = 5'd9;
        u_if2.adder1_in = '0;
        u_if2.read_reg1 = 5'd9;
        u_if2.read_reg2 = 5'd0;
        tick();
        tick();
        check("commit_in_reset", u_if.wb_commit, 0);
        check("wbdata_in_reset", u_if.wb_data, 32'h0000_1234);
        reset = 1'b0;
        reset2 = 1'b0;
        u_if.reg_write_in = 1'b0;
        #1;
        check("reset_r5", u_if.read_data1, 0);
        check("reset_count", u_if.write_count, 0);
        check("reset_illegal", u_if.illegal_sel, 0);

        u_if.reg_write_in = 1'b1;
        u_if.mem_to_reg_in = 2'b00;
        u_if.alu_result_in = 32'hAAAA_0001;
        u_if.write_reg_in = 5'd1;
        tick();
        u_if.mem_to_reg_in = 2'b01;
        u_if.data_from_memory_in = 32'hBBBB_0002;
        u_if.write_reg_in = 5'd2;
        tick();
        u_if.mem_to_reg_in = 2'b10;
        u_if.adder1_in = 32'h0040_0008;
        u_if.write_reg_in = 5'd31;
        tick();
        u_if.reg_write_in = 1'b0;
        u_if.mem_to_reg_in = 2'b00;
        u_if.read_reg1 = 5'd1;
        u_if.read_reg2 = 5'd2;
        #1;
        check("r1_alu", u_if.read_data1, 32'hAAAA_0001);
        check("r2_mem", u_if.read_data2, 32'hBBBB_0002);
        u_if.read_reg1 = 5'd31;
        #1;
        check("r31_link", u_if.read_data1, 32'h0040_0008);
        check("count_3", u_if.write_count, 3);

        u_if.reg_write_in = 1'b1;
        u_if.alu_result_in = 32'hDEAD_BEEF;
        u_if.write_reg_in = 5'd7;
        u_if.read_reg1 = 5'd7;
        u_if.read_reg2 = 5'd7;
        #1;
        check("bypass_p1", u_if.read_data1, 32'hDEAD_BEEF);
        check("bypass_p2", u_if.read_data2, 32'hDEAD_BEEF);
        check("bypass_commit", u_if.wb_commit, 1);
        tick();
        u_if.reg_write_in = 1'b0;
        u_if.alu_result_in = 32'h0;
        #1;
        check("r7_stored", u_if.read_data1, 32'hDEAD_BEEF);
        check("count_4", u_if.write_count, 4);

        u_if.reg_write_in = 1'b1;
        u_if.alu_result_in = 32'hFFFF_FFFF;
        u_if.write_reg_in = 5'd0;
        u_if.read_reg1 = 5'd0;
        u_if.read_reg2 = 5'd0;
        #1;
        check("r0_nobypass", u_if.read_data1, 0);
        check("r0_commit", u_if.wb_commit, 0);
        tick();
        u_if.reg_write_in = 1'b0;
        #1;
        check("r0_read", u_if.read_data2, 0);
        check("r0_count", u_if.write_count, 4);

        u_if.reg_write_in = 1'b1;
        u_if.alu_result_in = 32'h3333_3333;
        u_if.write_reg_in = 5'd3;
        tick();
        u_if.reg_write_in = 1'b0;
        u_if.mem_to_reg_in = 2'b11;
        tick();
        check("sel11_nowrite_flag", u_if.illegal_sel, 0);
        u_if.reg_write_in = 1'b1;
        u_if.read_reg1 = 5'd3;
        #1;
        check("illegal_wbdata", u_if.wb_data, 0);
        check("illegal_commit", u_if.wb_commit, 0);
        check("illegal_nobypass", u_if.read_data1, 32'h3333_3333);
        tick();
        u_if.reg_write_in = 1'b0;
        u_if.mem_to_reg_in = 2'b00;
        #1;
        check("illegal_r3", u_if.read_data1, 32'h3333_3333);
        check("illegal_set", u_if.illegal_sel, 1);
        check("illegal_count", u_if.write_count, 5);
        u_if.reg_write_in = 1'b1;
        u_if.alu_result_in = 32'h4444_0004;
        u_if.write_reg_in = 5'd4;
        tick();
        u_if.reg_write_in = 1'b0;
        u_if.read_reg2 = 5'd4;
        #1;
        check("r4_after_illegal", u_if.read_data2, 32'h4444_0004);
        check("illegal_sticky", u_if.illegal_sel, 1);
        check("count_6", u_if.write_count, 6);
        reset = 1'b1;
        #1;
        check("illegal_cleared", u_if.illegal_sel, 0);
        check("r4_cleared", u_if.read_data2, 0);
        reset = 1'b0;

        u_if2.reg_write_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            u_if2.alu_result_in = i;
            tick();
            if (i == 13) check("sat_count_14", u_if2.write_count, 14);
        end
        u_if2.reg_write_in = 1'b0;
        #1;
        check("sat_count_15", u_if2.write_count, 15);
        check("sat_r9_last", u_if2.read_data1, 19);
        #2;
        reset2 = 1'b1;
        #1;
        check("async_count_0", u_if2.write_count, 0);
        check("async_r9_0", u_if2.read_data1, 0);
        reset2 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
